// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART host-side FIFO controller: register map, bit positions, TX FSM states.
// Optional loopback feature is enabled by defining UART_CTRL_LOOPBACK_EN.
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_TX_FULL     = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_TX_OVERFLOW = 4;
    localparam int ST_TX_IDLE     = 5;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_LOOPBACK  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_SEND  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte-wide synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
// Used for both UART directions inside uart_fifo_ctrl.
module uart_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_wdata,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Host-side UART controller: TX/RX FIFOs, bus register file (DATA/STATUS/CTRL), TX drain FSM and level irq.
// Define UART_CTRL_LOOPBACK_EN to add CTRL bit2 loopback (TX head moved straight into the RX FIFO).
module uart_fifo_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_sel,
    input  logic       bus_we,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic       irq
);
    import uart_ctrl_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     r_state;
    logic          r_bus_ack, r_tx_start, r_irq;
    logic [7:0]    r_bus_rdata, r_tx_data;
    logic          r_rx_irq_en, r_tx_irq_en, r_rx_overrun, r_tx_overflow;
    logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic          w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]    w_tx_head, w_rx_head, w_rx_wdata;
    logic [CW-1:0] w_tx_count, w_rx_count;
    logic          w_rd, w_wr, w_ctrl_wr, w_status_wr, w_tx_idle;
    logic          w_loopback, w_lb_pop;
    logic [7:0]    w_status, w_ctrl, w_rd_value;
    logic          w_unused;

    assign w_rd        = bus_sel & ~bus_we;
    assign w_wr        = bus_sel & bus_we;
    assign w_ctrl_wr   = w_wr & (bus_addr == ADDR_CTRL);
    assign w_status_wr = w_wr & (bus_addr == ADDR_STATUS);
    assign w_tx_push   = w_wr & (bus_addr == ADDR_DATA);
    assign w_rx_pop    = w_rd & (bus_addr == ADDR_DATA) & ~w_rx_empty;
    assign w_tx_pop    = ((r_state == TX_START) & tx_busy) | w_lb_pop;
    assign w_tx_idle   = w_tx_empty & (r_state == TX_IDLE);
    assign w_unused    = ^{bus_wdata[7:5], bus_wdata[2], w_tx_count, w_rx_count};

`ifdef UART_CTRL_LOOPBACK_EN
    logic r_loopback;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loopback <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_loopback <= bus_wdata[CTRL_LOOPBACK];
        end
    end

    // In loopback the RX FIFO is fed only from the TX head; the serial receiver is ignored.
    assign w_loopback = r_loopback;
    assign w_lb_pop   = r_loopback & (r_state == TX_IDLE) & ~w_tx_empty;
    assign w_rx_push  = r_loopback ? w_lb_pop  : rx_data_ready;
    assign w_rx_wdata = r_loopback ? w_tx_head : rx_data;
`else
    assign w_loopback = 1'b0;
    assign w_lb_pop   = 1'b0;
    assign w_rx_push  = rx_data_ready;
    assign w_rx_wdata = rx_data;
`endif

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_tx_push),
        .i_wdata (bus_wdata),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rx_push),
        .i_wdata (w_rx_wdata),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    assign w_status = {2'b00, w_tx_idle, r_tx_overflow, r_rx_overrun, w_tx_full, w_tx_empty, ~w_rx_empty};
    assign w_ctrl   = {5'b00000, w_loopback, r_tx_irq_en, r_rx_irq_en};

    always_comb begin
        w_rd_value = 8'h00;
        case (bus_addr)
            ADDR_DATA:   w_rd_value = w_rx_empty ? 8'h00 : w_rx_head;
            ADDR_STATUS: w_rd_value = w_status;
            ADDR_CTRL:   w_rd_value = w_ctrl;
            default:     w_rd_value = 8'h00;
        endcase
    end

    // Sticky flags: a new drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_ack     <= 1'b0;
            r_bus_rdata   <= 8'h00;
            r_rx_irq_en   <= 1'b0;
            r_tx_irq_en   <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_overflow <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_bus_ack   <= bus_sel;
            r_bus_rdata <= w_rd ? w_rd_value : 8'h00;
            if (w_ctrl_wr) begin
                r_rx_irq_en <= bus_wdata[CTRL_RX_IRQ_EN];
                r_tx_irq_en <= bus_wdata[CTRL_TX_IRQ_EN];
            end
            r_rx_overrun  <= (w_rx_push & w_rx_full & ~w_rx_pop) |
                             (r_rx_overrun & ~(w_status_wr & bus_wdata[ST_RX_OVERRUN]));
            r_tx_overflow <= (w_tx_push & w_tx_full & ~w_tx_pop) |
                             (r_tx_overflow & ~(w_status_wr & bus_wdata[ST_TX_OVERFLOW]));
            r_irq <= (r_rx_irq_en & ~w_rx_empty) | (r_tx_irq_en & w_tx_empty) | r_rx_overrun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= TX_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (!w_loopback && !w_tx_empty && !tx_busy) begin
                        r_tx_data  <= w_tx_head;
                        r_tx_start <= 1'b1;
                        r_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_busy) begin
                        r_tx_start <= 1'b0;
                        r_state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!tx_busy) begin
                        r_state <= TX_IDLE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign bus_ack   = r_bus_ack;
    assign bus_rdata = r_bus_rdata;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign irq       = r_irq;

endmodule
